fetch_decode_queue: RTL
=======================

// Module: fetch_decode_queue
// PURPOSE
//  Small instruction FIFO between the fetch stage and the decode stage. Buffers
//  {instr, PCplus2} pairs so a decode stall does not freeze the PC every cycle.
//  Discards all buffered work on a taken branch/jump and holds intake after a HALT.
//  Emits a NOP to decode whenever it has nothing valid to present.
// PARAMETERS
//  DEPTH  4   entries; power of two, >= 2
//  WIDTH  16  instruction and PC width in bits
// PORTS
//  clk         in   1      system clock; all state updates on rising edge
//  rst         in   1      reset, asynchronous, active-low (0 = reset)
//  in_valid    in   1      fetch offers an entry this cycle
//  in_ready    out  1      queue accepts an entry this cycle
//  in_instr    in   WIDTH  fetched instruction
//  in_pcplus2  in   WIDTH  PC+2 of that instruction
//  flush       in   1      branch/jump taken; discard all entries
//  out_valid   out  1      out_instr/out_pcplus2 hold a real entry
//  out_ready   in   1      decode consumes the head entry this cycle
//  out_instr   out  WIDTH  head instruction; 16'h0800 (NOP) when !out_valid
//  out_pcplus2 out  WIDTH  head PC+2; 16'h0000 when !out_valid
//  count       out  clog2(DEPTH)+1  entries currently held
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): count=0, rd/wr pointers=0, state=RUN,
//    out_valid=0, out_instr=16'h0800, out_pcplus2=0, in_ready=1. Storage not cleared.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (state==RUN) & (count!=DEPTH). No combinational path from out_ready
//    to in_ready: when full, a push is refused even if a pop occurs that cycle.
//  - out_valid = (count!=0); out_instr/out_pcplus2 = storage[rd_ptr] when valid.
//  - Latency: an entry pushed at edge N is visible at the output after edge N
//    (earliest pop in cycle N+1). No bypass when empty.
//  - Simultaneous push and pop (not full, not empty): count unchanged, both
//    pointers advance. Pointers wrap modulo DEPTH.
//  - flush has priority over everything: at the edge count=0, pointers=0,
//    state=RUN; same-cycle push and pop are ignored (pop side-effect-free).
//  - State machine, 2 states:
//      RUN : normal. On a push whose in_instr[15:11]==5'b00000 (HALT) -> HOLD.
//            The HALT entry itself is stored normally.
//      HOLD: in_ready=0; pops continue, draining the queue (HALT reaches decode).
//            flush -> RUN. Only reset or flush leave HOLD.
//  - count never exceeds DEPTH nor underflows; pop when empty impossible
//    since out_valid=0.
//  - rst asserted mid-operation: all entries lost immediately, outputs take
//    reset values without waiting for clk.
// TESTING
//  1. Reset, then push 16'h4001/pc 2, 16'h4102/pc 4 with out_ready=0 -> count=2,
//     out_instr=16'h4001, out_pcplus2=2, out_valid=1; in_ready stays 1.
//  2. Push 5 entries, out_ready=0, DEPTH=4 -> in_ready=0 after 4th, count=4, 5th
//     refused; then out_ready=1 for 4 cycles -> entries drained in order, NOP shown.
//  3. Full queue, in_valid=1 and out_ready=1 same cycle -> pop only, count=3;
//     next cycle push accepted, count=4; wrap order preserved over 3 refills.
//  4. count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0,
//     out_valid=0, out_instr=16'h0800.
//  5. Push 16'h0000 (HALT) then in_valid=1 continuously -> in_ready=0 after HALT;
//     queue drains to HALT then empty; flush -> in_ready=1, state RUN.
//  6. count=2, drop rst mid-cycle -> out_valid=0, count=0 before next clk edge;
//     release rst -> push accepted normally.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue
//   Small instruction FIFO between the fetch and decode stages. It holds
//   {instr, pcplus2} pairs so that a decode stall does not freeze the PC. A
//   taken branch/jump (flush) discards all buffered entries. A HALT
//   instruction stops further intake until the next flush. Decode sees a NOP
//   whenever the queue has nothing valid to present.
//
//   Handshake: both sides use valid/ready. A transfer happens in a cycle where
//   valid and ready are both high at the rising edge. in_ready depends only on
//   registered state (the FSM state and count), never on out_ready. out_valid
//   depends only on count.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   in_valid     fetch offers an entry
//   in_ready     queue can accept an entry
//   in_instr     fetched instruction
//   in_pcplus2   PC+2 of that instruction
//   flush        branch/jump taken: drop everything, resume intake
//   out_valid    out_instr/out_pcplus2 hold a real entry
//   out_ready    decode consumes the head entry
//   out_instr    head instruction, NOP (16'h0800) when empty
//   out_pcplus2  head PC+2, zero when empty
//   count        number of entries held
// -----------------------------------------------------------------------------
module fetch_decode_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_instr,
    input  logic [WIDTH-1:0]         in_pcplus2,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_instr,
    output logic [WIDTH-1:0]         out_pcplus2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [WIDTH-1:0] NOP_INSTR = WIDTH'(16'h0800);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic             push;
    logic             pop;
    logic             is_halt;

    assign push    = in_valid & in_ready;
    assign pop     = out_valid & out_ready;
    // HALT is identified by a zero opcode field in the top five bits.
    assign is_halt = (in_instr[WIDTH-1 -: 5] == 5'b00000);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: flush wins over everything, including a HALT push.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = RUN;
        end else if (state == RUN && push && is_halt) begin
            state_nxt = HOLD;
        end
    end

    // Output logic
    always_comb begin
        in_ready    = (state == RUN) && (count != CW'(DEPTH));
        out_valid   = (count != '0);
        out_instr   = NOP_INSTR;
        out_pcplus2 = '0;
        if (out_valid) begin
            out_instr   = instr_mem[rd_ptr];
            out_pcplus2 = pc_mem[rd_ptr];
        end
    end

    // Pointers and occupancy. A flush cancels any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; entries are only ever read while count says valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pcplus2;
        end
    end

endmodule
